// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// A winner's byte is issued with a one-cycle strobe; the arbiter then waits
// for the transmitter's done flag (or a watchdog expiry) before acknowledging
// the winner and advancing the priority pointer.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 6000,  // cycles allowed in WAIT before abort; must exceed one UART frame
    parameter int CNT_W   = 16     // watchdog width; TIMEOUT must be below 2**CNT_W
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  i_Req,
    input  logic [31:0] i_Data,
    output logic [3:0]  o_Ack,
    output logic [1:0]  o_Grant,
    output logic        o_Busy,
    output logic        o_fTimeout,
    output logic        o_fTx,
    output logic [7:0]  o_TxData,
    input  logic        i_TxReady,
    input  logic        i_TxDone
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [1:0]       last;        // most recently served requester
    logic [CNT_W-1:0] wdog;        // cycles spent in WAIT
    logic [1:0]       cand;
    logic [1:0]       winner;
    logic             winner_vld;

    // Search requesters last+1, last+2, ... (mod 4) and take the first pending one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        cand       = '0;
        winner     = '0;
        winner_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!winner_vld && i_Req[cand]) begin
                winner     = cand;
                winner_vld = 1'b1;
            end
        end
    end

    // Arbitration FSM: grant, wait for done or watchdog expiry, one-cycle ack.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            last       <= 2'd3;
            wdog       <= '0;
            o_Ack      <= '0;
            o_Grant    <= '0;
            o_Busy     <= 1'b0;
            o_fTimeout <= 1'b0;
            o_fTx      <= 1'b0;
            o_TxData   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here updates
            // from the values held before this edge (o_fTx in WAIT is the old strobe).
            case (state)
                S_IDLE: begin
                    o_fTx <= 1'b0;
                    if (i_TxReady && winner_vld) begin
                        o_Grant  <= winner;
                        o_TxData <= i_Data[{winner, 3'b000} +: 8];
                        o_fTx    <= 1'b1;
                        o_Busy   <= 1'b1;
                        wdog     <= '0;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    o_fTx <= 1'b0;
                    wdog  <= wdog + 1'b1;
                    // Done is not trusted on the strobe edge itself; done beats expiry.
                    if (i_TxDone && !o_fTx) begin
                        o_Ack      <= 4'b0001 << o_Grant;
                        o_fTimeout <= 1'b0;
                        last       <= o_Grant;
                        state      <= S_ACK;
                    end else if (wdog == WDOG_LAST) begin
                        o_Ack      <= 4'b0001 << o_Grant;
                        o_fTimeout <= 1'b1;
                        last       <= o_Grant;
                        state      <= S_ACK;
                    end
                end

                S_ACK: begin
                    o_Ack  <= '0;
                    o_Busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a behavioural UART transmitter,
// requesters that drop or re-arm on their ack, a round-robin service-order
// model feeding an expectation queue, and a monitor that pops and compares.
module tb_uart_tx_arbiter;

    localparam int TIMEOUT = 50;

    logic        Clk;
    logic        Rst;
    logic [3:0]  i_Req;
    logic [31:0] i_Data;
    logic [3:0]  o_Ack;
    logic [1:0]  o_Grant;
    logic        o_Busy;
    logic        o_fTimeout;
    logic        o_fTx;
    logic [7:0]  o_TxData;
    logic        i_TxReady;
    logic        i_TxDone;

    uart_tx_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_Req     (i_Req),
        .i_Data    (i_Data),
        .o_Ack     (o_Ack),
        .o_Grant   (o_Grant),
        .o_Busy    (o_Busy),
        .o_fTimeout(o_fTimeout),
        .o_fTx     (o_fTx),
        .o_TxData  (o_TxData),
        .i_TxReady (i_TxReady),
        .i_TxDone  (i_TxDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state
    int         model_last = 3;
    logic [7:0] byte_tab [4][8];
    int         rearm [4];
    int         drv_srv [4];

    // UART transmitter model
    int frame_len  = 8;
    bit hang       = 1'b0;
    bit ready_gate = 1'b1;
    bit uart_ready = 1'b1;
    int uart_cnt   = 0;

    // Monitor state
    exp_t cur;
    bit   cur_valid = 1'b0;
    int   cyc       = 0;
    int   grant_cyc = 0;
    int   done_cyc  = -100;
    bit   prev_tx   = 1'b0;
    bit   prev_ack  = 1'b0;
    int   tx_count  = 0;
    int   ack_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Expected service order: repeatedly pick the first requester after the
    // last served one (cyclically) that still has serves left.
    task automatic plan(input int reps [4], input bit tmo);
        int   rem [4];
        int   srv [4];
        int   idx;
        bit   found;
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            rem[n] = reps[n];
            srv[n] = 0;
        end
        do begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (model_last + k) % 4;
                if (!found && rem[idx] > 0) begin
                    e.grant = 2'(idx);
                    e.data  = byte_tab[idx][srv[idx]];
                    e.tmo   = tmo;
                    exp_q.push_back(e);
                    srv[idx]++;
                    rem[idx]--;
                    model_last = idx;
                    found = 1'b1;
                end
            end
        end while (found);
    endtask

    // Present requests: reps[n] serves of requester n, bytes from byte_tab.
    task automatic start_reqs(input int reps [4], input bit tmo);
        logic [3:0] mask;
        mask = '0;
        for (int n = 0; n < 4; n++) begin
            rearm[n]   = (reps[n] > 0) ? reps[n] - 1 : 0;
            drv_srv[n] = 0;
            i_Data[8*n +: 8] = byte_tab[n][0];
            mask[n] = (reps[n] > 0);
        end
        plan(reps, tmo);
        i_Req = mask;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (i_Req == 4'b0 && exp_q.size() == 0 && !cur_valid && !o_Busy && i_TxReady) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("idle_reached", ok, 1'b1);
    endtask

    // Monitor, requester driver and UART model share one negedge process.
    initial begin
        forever begin
            @(negedge Clk);
            cyc++;
            if (Rst) begin
                cur_valid = 1'b0;
                prev_tx   = 1'b0;
                prev_ack  = 1'b0;
            end else begin
                if (o_fTx) begin
                    check("ftx_one_cycle", prev_tx, 1'b0);
                    check("ready_at_grant", i_TxReady, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: grant %0d data %0h, expected no transfer", o_Grant, o_TxData);
                    end else begin
                        cur = exp_q.pop_front();
                        check("grant", o_Grant, cur.grant);
                        check("tx_data", o_TxData, cur.data);
                        cur_valid = 1'b1;
                        grant_cyc = cyc;
                    end
                    tx_count++;
                end
                if (o_Ack != 4'b0) begin
                    check("ack_one_cycle", prev_ack, 1'b0);
                    if (!cur_valid) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: ack %b, expected none", o_Ack);
                    end else begin
                        check("ack_onehot", o_Ack, 32'd1 << cur.grant);
                        check("ack_timeout_flag", o_fTimeout, cur.tmo);
                        if (cur.tmo) check("timeout_latency", cyc - grant_cyc, TIMEOUT);
                        else         check("ack_latency", cyc - done_cyc, 1);
                    end
                    cur_valid = 1'b0;
                    ack_count++;
                end
                check("busy", o_Busy, (cur_valid || o_Ack != 4'b0));
                prev_tx  = o_fTx;
                prev_ack = (o_Ack != 4'b0);
                // Requesters: reload next byte or drop on their ack.
                for (int n = 0; n < 4; n++) begin
                    if (o_Ack[n]) begin
                        if (rearm[n] > 0) begin
                            rearm[n]--;
                            drv_srv[n]++;
                            i_Data[8*n +: 8] = byte_tab[n][drv_srv[n]];
                        end else begin
                            i_Req[n] = 1'b0;
                        end
                    end
                end
            end
            // UART transmitter: busy for frame_len cycles after a strobe.
            i_TxDone = 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    if (!hang) begin
                        i_TxDone = 1'b1;
                        done_cyc = cyc;
                    end
                    uart_ready = 1'b1;
                end
            end
            if (o_fTx) begin
                uart_ready = 1'b0;
                uart_cnt   = frame_len;
            end
            i_TxReady = uart_ready & ready_gate;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         reps [4];
        int         txb;
        int         ackb;
        bit         seen;
        logic [7:0] b;

        Rst       = 1'b1;
        i_Req     = '0;
        i_Data    = '0;
        i_TxReady = 1'b1;
        i_TxDone  = 1'b0;
        for (int n = 0; n < 4; n++)
            for (int k = 0; k < 8; k++)
                byte_tab[n][k] = '0;

        // Reset state
        repeat (2) tick();
        check("rst_ack", o_Ack, 4'b0);
        check("rst_grant", o_Grant, 2'd0);
        check("rst_busy", o_Busy, 1'b0);
        check("rst_timeout", o_fTimeout, 1'b0);
        check("rst_ftx", o_fTx, 1'b0);
        check("rst_txdata", o_TxData, 8'h00);
        Rst = 1'b0;
        tick();

        // All four requesting: order 0,1,2,3 from reset pointer
        byte_tab[0][0] = 8'h10; byte_tab[1][0] = 8'h21;
        byte_tab[2][0] = 8'h32; byte_tab[3][0] = 8'h43;
        reps = '{1, 1, 1, 1};
        start_reqs(reps, 1'b0);
        wait_idle(400);

        // Single request
        byte_tab[0][0] = 8'h3C;
        reps = '{1, 0, 0, 0};
        start_reqs(reps, 1'b0);
        wait_idle(200);
        check("single_no_timeout", o_fTimeout, 1'b0);

        // Fairness: 0 and 2 re-armed after each ack
        for (int k = 0; k < 4; k++) begin
            byte_tab[0][k] = 8'(8'h80 + k);
            byte_tab[2][k] = 8'(8'hA0 + k);
        end
        reps = '{4, 0, 4, 0};
        start_reqs(reps, 1'b0);
        wait_idle(800);

        // Watchdog timeout on requester 1
        hang = 1'b1;
        byte_tab[1][0] = 8'h5A;
        reps = '{0, 1, 0, 0};
        start_reqs(reps, 1'b1);
        wait_idle(200);
        check("timeout_flag_holds", o_fTimeout, 1'b1);
        hang = 1'b0;
        byte_tab[0][0] = 8'h66;
        reps = '{1, 0, 0, 0};
        start_reqs(reps, 1'b0);
        wait_idle(200);
        check("timeout_flag_cleared", o_fTimeout, 1'b0);

        // Reset mid-WAIT, 20 cycles after grant, with a long frame in flight
        frame_len = 40;
        byte_tab[2][0] = 8'hC7;
        reps = '{0, 0, 1, 0};
        txb = tx_count;
        start_reqs(reps, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_count != txb) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_test_grant_seen", seen, 1'b1);
        repeat (19) tick();
        ackb = ack_count;
        Rst = 1'b1;
        tick();
        check("midrst_ack", o_Ack, 4'b0);
        check("midrst_grant", o_Grant, 2'd0);
        check("midrst_busy", o_Busy, 1'b0);
        check("midrst_ftx", o_fTx, 1'b0);
        check("midrst_txdata", o_TxData, 8'h00);
        Rst = 1'b0;
        model_last = 3;
        plan(reps, 1'b0);
        tick();
        check("midrst_no_ack", ack_count, ackb);
        check("midrst_waits_ready", tx_count, txb + 1);
        wait_idle(300);
        frame_len = 8;

        // Not ready: no strobe until ready rises, then grant 3 at once
        ready_gate = 1'b0;
        i_TxReady  = 1'b0;
        byte_tab[3][0] = 8'hE9;
        reps = '{0, 0, 0, 1};
        txb = tx_count;
        start_reqs(reps, 1'b0);
        repeat (10) tick();
        check("no_tx_while_not_ready", tx_count, txb);
        ready_gate = 1'b1;
        i_TxReady  = uart_ready;
        tick();
        check("ready_grant_ftx", o_fTx, 1'b1);
        check("ready_grant_idx", o_Grant, 2'd3);
        wait_idle(200);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            frame_len = $urandom_range(3, 20);
            for (int n = 0; n < 4; n++) begin
                reps[n] = $urandom_range(0, 2);
                for (int k = 0; k < 8; k++) begin
                    b = 8'($urandom);
                    byte_tab[n][k] = b;
                end
            end
            if (reps[0] + reps[1] + reps[2] + reps[3] == 0)
                reps[$urandom_range(0, 3)] = 1;
            start_reqs(reps, 1'b0);
            wait_idle(8 * (TIMEOUT + 10));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `UART_TX` instance among four byte requesters, e.g. the four push-button message sources inside `UART_Top`. It sits between the requesters and the `UART_TX` `i_fTx`/`i_Data` inputs. It selects one pending request, issues its byte as a single-cycle `i_fTx` strobe, and waits for `o_fDone`. It then acknowledges the winner and moves the priority pointer. A watchdog counter recovers from a `UART_TX` that never reports done.

## Interface
Parameters:
- `TIMEOUT`, default 6000: cycles allowed in WAIT for `i_TxDone` before abort. Must exceed one UART frame (10 bit times).
- `CNT_W`, default 16: watchdog counter width. Requires `TIMEOUT < 2**CNT_W`.

Ports:
- `Clk`  in  1: single clock; all logic on the rising edge.
- `Rst`  in  1: reset, synchronous, active-high.
- `i_Req`  in  4: request per requester. Held high, with data stable, until that requester's `o_Ack` bit is seen.
- `i_Data`  in  32: requester n's byte is `i_Data[8n+7:8n]`.
- `o_Ack`  out  4: one-cycle pulse to the served requester (one-hot).
- `o_Grant`  out  2: index of the current or last served requester.
- `o_Busy`  out  1: high in WAIT and ACK.
- `o_fTimeout`  out  1: high when the last transfer was aborted by the watchdog.
- `o_fTx`  out  1: to `UART_TX i_fTx`; one-cycle strobe.
- `o_TxData`  out  8: to `UART_TX i_Data`; byte latched at grant.
- `i_TxReady`  in  1: from `UART_TX o_fReady`.
- `i_TxDone`  in  1: from `UART_TX o_fDone`.

## Operation
- States: IDLE, WAIT, ACK. All outputs are registered.
- Reset values, applied at the first edge with `Rst=1`:
  - state=IDLE; all outputs 0 (`o_Ack`, `o_Grant`, `o_Busy`, `o_fTimeout`, `o_fTx`, `o_TxData`).
  - Priority pointer `Last`=3, so requester 0 has highest priority first.
- IDLE, on an edge where `i_TxReady=1` and `|i_Req`:
  - Winner = first set bit of `i_Req`, searching `Last+1`, `Last+2`, … modulo 4.
  - `o_Grant`←winner; `o_TxData`←winner's byte; `o_fTx`←1; watchdog←0; state→WAIT.
- IDLE with `i_TxReady=0` or no request: hold all outputs; `o_fTx`=0.
- WAIT:
  - `o_fTx` returns to 0 after one cycle.
  - Watchdog increments every cycle.
  - `i_TxDone` is ignored on the edge where `o_fTx=1`.
  - On `i_TxDone=1`: `o_Ack[o_Grant]`←1, `o_fTimeout`←0, `Last`←`o_Grant`, state→ACK.
  - Else on watchdog = `TIMEOUT-1`: `o_Ack[o_Grant]`←1, `o_fTimeout`←1, `Last`←`o_Grant`, state→ACK.
  - If `i_TxDone` and watchdog expiry land on the same edge, done wins (`o_fTimeout`=0).
- ACK: lasts exactly one cycle with `o_Ack` high, then `o_Ack`←0 and state→IDLE.
- `o_Busy` = 1 in WAIT and ACK.
- `o_fTimeout` holds its value until the next completion or reset.
- Requester rules:
  - A requester drops or reloads `i_Req` on the edge where it samples `o_Ack=1`.
  - The arbiter does not re-arbitrate before the IDLE cycle that follows ACK, so a served request is never granted twice.
- Request withdrawal:
  - Before grant: no effect.
  - During WAIT: ignored; the transfer completes and the ack is still pulsed.
  - Changing `i_Data` after grant does not affect `o_TxData`.
- Reset mid-transfer: the arbiter returns to IDLE at once. A frame already in `UART_TX` finishes on its own. The arbiter grants again only once `i_TxReady=1`.

## Timing
- Grant latency: request sampled at edge k (IDLE, ready) → `o_fTx=1` and `o_TxData` valid from edge k to edge k+1.
- Ack latency: `i_TxDone` sampled at edge d → `o_Ack` high from d to d+1 → IDLE after d+1.
- Earliest next grant is edge d+2, giving at least 2 idle cycles between consecutive `o_fTx` strobes.
- Timeout: `o_Ack` rises exactly `TIMEOUT` edges after the grant edge.
- Throughput: one byte per UART frame plus 3 cycles.

## Test plan
- Single request: `i_Req`=0001, `i_Data[7:0]`=8'h3C.
  - Expect `o_fTx` for 1 cycle with `o_TxData`=8'h3C, `o_Grant`=0.
  - A loopback `UART_RX` receives 3C; `o_Ack`=0001 for 1 cycle; `o_fTimeout`=0.
- All four requesting (bytes 8'h10, 8'h21, 8'h32, 8'h43), each dropped on its ack.
  - Expect grants in order 0,1,2,3; RX sequence 10,21,32,43.
  - Each `o_Ack` is exactly 1 cycle wide.
- Fairness: requesters 0 and 2 held continuously and re-armed after each ack.
  - Expect grants alternating 0,2,0,2, never two consecutive grants to the same requester.
- Timeout: tie `i_TxDone`=0 with `TIMEOUT`=50, request on 1.
  - Expect `o_Ack`=0010 exactly 50 edges after grant, with `o_fTimeout`=1.
  - The next normal transfer clears `o_fTimeout` to 0.
- Reset mid-WAIT: assert `Rst` for 1 cycle 20 cycles after grant.
  - Expect all outputs 0 on the next edge and no `o_Ack` for the aborted request.
  - Re-grant only after `i_TxReady` returns to 1.
- Not ready: hold `i_TxReady`=0 with `i_Req`=1000.
  - Expect no `o_fTx`.
  - After `i_TxReady` goes to 1 at edge r, `o_fTx` is high from r to r+1 with `o_Grant`=3.
